serial_add_ctrl: RTL and testbench

Bit-serial adder controller that sequences a single full_adder cell to add two WIDTH-bit operands, one bit per clock, LSB first. It provides a start/busy/done handshake, holds the carry in a flip-flop between bit slices, and assembles the sum in a shift register. It is used where area matters more than latency and one 1-bit adder cell is shared across all bit positions.

---
 rtl/serial_add_pkg.sv | 15 +
 rtl/full_adder.sv | 13 +
 rtl/serial_add_ctrl.sv | 134 +++++++++++++
 tb/tb_serial_add_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_add_pkg.sv
// Shared types and helpers for the bit-serial adder controller.
// The counter width helper keeps WIDTH=1 from producing a zero-width counter.
package serial_add_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ADD,
        DONE
    } sa_state_t;

    function automatic int cnt_w(input int w);
        return (w <= 1) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder cell, shared across every bit position by the controller.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic c
);

    assign s = a ^ b ^ cin;
    assign c = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one full_adder cell adds two WIDTH-bit operands LSB first,
// one bit per clock, with a start/busy/done handshake and registered results.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int            CW       = cnt_w(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    sa_state_t        state_q, state_d;
    logic [WIDTH-1:0] a_sh_q,  a_sh_d;
    logic [WIDTH-1:0] b_sh_q,  b_sh_d;
    logic [WIDTH-1:0] s_sh_q,  s_sh_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q,   cnt_d;
    logic             busy_q,  busy_d;
    logic             done_q,  done_d;
    logic [WIDTH-1:0] sum_q,   sum_d;
    logic             cout_q,  cout_d;

    logic             fa_s;
    logic             fa_c;
    logic [WIDTH-1:0] s_shift;

    full_adder u_fa (
        .a   (a_sh_q[0]),
        .b   (b_sh_q[0]),
        .cin (carry_q),
        .s   (fa_s),
        .c   (fa_c)
    );

    // New sum bit enters at the MSB; after WIDTH slices bit 0 has reached the LSB.
    generate
        if (WIDTH == 1) begin : g_shift_w1
            assign s_shift = fa_s;
        end else begin : g_shift_wn
            assign s_shift = {fa_s, s_sh_q[WIDTH-1:1]};
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        s_sh_d  = s_sh_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        sum_d   = sum_q;
        cout_d  = cout_q;

        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (start) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    carry_d = cin;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = ADD;
                end
            end
            ADD: begin
                s_sh_d  = s_shift;
                carry_d = fa_c;
                a_sh_d  = a_sh_q >> 1;
                b_sh_d  = b_sh_q >> 1;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CNT_LAST) begin
                    sum_d   = s_shift;
                    cout_d  = fa_c;
                    done_d  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            s_sh_q  <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            s_sh_q  <= s_sh_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl at WIDTH=8, 13 and 1 against an
// arithmetic reference model ({cout,sum} = a + b + cin).
module tb_serial_add_ctrl;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        start;
    logic [63:0] a_in;
    logic [63:0] b_in;
    logic        cin_in;
    int          sel;

    logic start8, start13, start1;
    assign start8  = start && (sel == 8);
    assign start13 = start && (sel == 13);
    assign start1  = start && (sel == 1);

    logic        busy8,  done8,  cout8;
    logic [7:0]  sum8;
    logic        busy13, done13, cout13;
    logic [12:0] sum13;
    logic        busy1,  done1,  cout1;
    logic [0:0]  sum1;

    serial_add_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8),
        .a(a_in[7:0]), .b(b_in[7:0]), .cin(cin_in),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
    );

    serial_add_ctrl #(.WIDTH(13)) dut13 (
        .clk(clk), .rst(rst), .start(start13),
        .a(a_in[12:0]), .b(b_in[12:0]), .cin(cin_in),
        .busy(busy13), .done(done13), .sum(sum13), .cout(cout13)
    );

    serial_add_ctrl #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1),
        .a(a_in[0:0]), .b(b_in[0:0]), .cin(cin_in),
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
    );

    logic        obs_busy, obs_done, obs_cout;
    logic [63:0] obs_sum;

    always_comb begin
        obs_busy = 1'b0;
        obs_done = 1'b0;
        obs_cout = 1'b0;
        obs_sum  = '0;
        case (sel)
            8:  begin obs_busy = busy8;  obs_done = done8;  obs_cout = cout8;  obs_sum = 64'(sum8);  end
            13: begin obs_busy = busy13; obs_done = done13; obs_cout = cout13; obs_sum = 64'(sum13); end
            1:  begin obs_busy = busy1;  obs_done = done1;  obs_cout = cout1;  obs_sum = 64'(sum1);  end
            default: ;
        endcase
    end

    int          tests = 0;
    int          fails = 0;
    logic [64:0] last_res [0:64];

    function automatic logic [64:0] model(input int w, input logic [63:0] av,
                                          input logic [63:0] bv, input logic c);
        logic [63:0] m;
        logic [64:0] r;
        m = (64'd1 << w) - 64'd1;
        r = {1'b0, av & m} + {1'b0, bv & m} + 65'(c);
        return r & ((65'd1 << (w + 1)) - 65'd1);
    endfunction

    function automatic logic [64:0] obs_res(input int w);
        return {1'b0, obs_sum} | (65'(obs_cout) << w);
    endfunction

    task automatic wait_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_model();
        for (int i = 0; i <= 64; i++) last_res[i] = '0;
    endtask

    // One full transaction: start, latency, result, done width, post-done stability.
    task automatic do_op(input int w, input logic [63:0] av, input logic [63:0] bv,
                         input logic c, input int gap, input string name);
        logic [64:0] exp;
        int          n;
        exp    = model(w, av, bv, c);
        sel    = w;
        a_in   = av;
        b_in   = bv;
        cin_in = c;
        start  = 1'b1;
        wait_edge();
        start  = 1'b0;
        a_in   = {$urandom, $urandom};
        b_in   = {$urandom, $urandom};
        cin_in = 1'($urandom);
        tests++;
        if (obs_busy !== 1'b1) begin
            fails++;
            $display("FAIL %s busy_after_start: got %b want 1", name, obs_busy);
        end
        n = 0;
        while (obs_done !== 1'b1 && n < w + 4) begin
            tests++;
            if (obs_res(w) !== last_res[w]) begin
                fails++;
                $display("FAIL %s sum_stable_in_add: got %h want %h", name, obs_res(w), last_res[w]);
            end
            wait_edge();
            n++;
        end
        tests++;
        if (n !== w) begin
            fails++;
            $display("FAIL %s done_latency: got %0d want %0d", name, n, w);
        end
        tests++;
        if (obs_res(w) !== exp) begin
            fails++;
            $display("FAIL %s result: got %h want %h", name, obs_res(w), exp);
        end
        last_res[w] = exp;
        wait_edge();
        tests++;
        if (obs_done !== 1'b0 || obs_busy !== 1'b0) begin
            fails++;
            $display("FAIL %s done_width_busy_fall: got done=%b busy=%b want 0/0", name, obs_done, obs_busy);
        end
        for (int g = 0; g < gap; g++) begin
            wait_edge();
            tests++;
            if (obs_res(w) !== last_res[w] || obs_done !== 1'b0) begin
                fails++;
                $display("FAIL %s idle_stable: got %h done=%b want %h done=0", name, obs_res(w), obs_done, last_res[w]);
            end
        end
        $display("[TB] %s w=%0d a=%h b=%h cin=%b -> %h", name, w, av, bv, c, exp);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        a_in = '0;
        b_in = '0;
        cin_in = 1'b0;
        sel = 8;
        clear_model();
        repeat (3) wait_edge();
        tests++;
        if ({busy8, done8, sum8, cout8} !== '0) begin
            fails++;
            $display("FAIL reset_w8: got busy=%b done=%b sum=%h cout=%b want all 0", busy8, done8, sum8, cout8);
        end
        tests++;
        if ({busy13, done13, sum13, cout13} !== '0) begin
            fails++;
            $display("FAIL reset_w13: got busy=%b done=%b sum=%h cout=%b want all 0", busy13, done13, sum13, cout13);
        end
        tests++;
        if ({busy1, done1, sum1, cout1} !== '0) begin
            fails++;
            $display("FAIL reset_w1: got busy=%b done=%b sum=%h cout=%b want all 0", busy1, done1, sum1, cout1);
        end
        rst = 1'b0;
        $display("[TB] reset checked");
    endtask

    task automatic test_basic();
        do_op(8, 64'h5A, 64'h3C, 1'b0, 1, "add_5a_3c");
        do_op(8, 64'hFF, 64'h01, 1'b0, 0, "carry_ff_01");
        do_op(8, 64'hFF, 64'h00, 1'b1, 2, "carry_ff_cin");
        do_op(8, 64'h80, 64'h80, 1'b1, 0, "carry_80_80");
    endtask

    task automatic test_back_to_back();
        int          n;
        logic [64:0] exp;
        sel = 8;
        a_in = 64'h10;
        b_in = 64'h20;
        cin_in = 1'b0;
        start = 1'b1;
        wait_edge();
        n = 0;
        while (obs_done !== 1'b1 && n < 12) begin
            wait_edge();
            n++;
            if (n == 3) begin
                a_in = 64'hAA;
                b_in = 64'h55;
            end
        end
        tests++;
        if (n !== 8) begin
            fails++;
            $display("FAIL b2b_latency1: got %0d want 8", n);
        end
        exp = model(8, 64'h10, 64'h20, 1'b0);
        tests++;
        if (obs_res(8) !== exp) begin
            fails++;
            $display("FAIL b2b_result1: got %h want %h", obs_res(8), exp);
        end
        wait_edge();
        tests++;
        if (obs_busy !== 1'b0 || obs_done !== 1'b0) begin
            fails++;
            $display("FAIL b2b_gap_cycle: got busy=%b done=%b want 0/0", obs_busy, obs_done);
        end
        wait_edge();
        start = 1'b0;
        tests++;
        if (obs_busy !== 1'b1) begin
            fails++;
            $display("FAIL b2b_restart: got busy=%b want 1", obs_busy);
        end
        n = 0;
        while (obs_done !== 1'b1 && n < 12) begin
            wait_edge();
            n++;
        end
        exp = model(8, 64'hAA, 64'h55, 1'b0);
        tests++;
        if (n !== 8 || obs_res(8) !== exp) begin
            fails++;
            $display("FAIL b2b_result2: got lat=%0d res=%h want lat=8 res=%h", n, obs_res(8), exp);
        end
        last_res[8] = exp;
        wait_edge();
        $display("[TB] back_to_back done");
    endtask

    task automatic test_reset_abort();
        int seen;
        sel = 8;
        a_in = 64'h33;
        b_in = 64'h44;
        cin_in = 1'b0;
        start = 1'b1;
        wait_edge();
        start = 1'b0;
        repeat (4) wait_edge();
        rst = 1'b1;
        #1;
        tests++;
        if (busy8 !== 1'b0 || done8 !== 1'b0 || sum8 !== 8'h00 || cout8 !== 1'b0) begin
            fails++;
            $display("FAIL abort_async_clear: got busy=%b done=%b sum=%h cout=%b want all 0", busy8, done8, sum8, cout8);
        end
        clear_model();
        wait_edge();
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            wait_edge();
            if (done8 === 1'b1) seen++;
        end
        tests++;
        if (seen !== 0) begin
            fails++;
            $display("FAIL abort_no_done: got %0d pulses want 0", seen);
        end
        do_op(8, 64'h01, 64'h01, 1'b0, 0, "post_reset");
    endtask

    task automatic test_random(input int w, input int count);
        for (int i = 0; i < count; i++) begin
            do_op(w, {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom),
                  int'($urandom_range(0, 3)), "random");
        end
    endtask

    task automatic test_width1();
        do_op(1, 64'h1, 64'h1, 1'b1, 0, "w1_all_ones");
        do_op(1, 64'h1, 64'h0, 1'b0, 1, "w1_one");
        do_op(1, 64'h0, 64'h0, 1'b1, 0, "w1_cin");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_reset_abort();
        test_random(8, 500);
        test_random(13, 500);
        test_width1();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
